// File: rtl/cam_match_select_pkg.sv
// Shared types and helpers for the CAM match-select stage.
// Sizing constants, FSM state enum, partition-mask expansion.
package cam_match_select_pkg;

  localparam int DEPTH         = 32;
  localparam int INDEX         = 5;
  localparam int NUM_RD_PORTS  = 2;
  localparam int NUM_WR_PORTS  = 2;
  localparam int NUM_CLR_PORTS = 2;
  localparam int NUM_PARTS     = 4;
  localparam int NUM_PARTS_LOG = 2;
  localparam int PART_SIZE     = DEPTH / NUM_PARTS;

  typedef enum logic [1:0] {
    WAIT_RAM,
    RUN,
    FLUSH
  } camState_e;

  function automatic logic [DEPTH-1:0] expandParts(
    input logic [NUM_PARTS-1:0] parts
  );
    logic [DEPTH-1:0] m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = parts[i/PART_SIZE];
    end
    return m;
  endfunction

  function automatic logic [DEPTH-1:0] partMask(
    input logic [NUM_PARTS_LOG-1:0] p
  );
    return expandParts(NUM_PARTS'(1) << p);
  endfunction

endpackage

// File: rtl/cam_match_select_if.sv
// Bus bundle between CAM match-select stage and its neighbours.
// master drives search/alloc/control, slave (the stage) returns hits.
interface cam_match_select_if;
  import cam_match_select_pkg::*;

  logic                                camReady_i;
  logic [NUM_PARTS-1:0]                partitionGated_i;
  logic [NUM_RD_PORTS-1:0]             readPortGated_i;
  logic [NUM_RD_PORTS-1:0][DEPTH-1:0]  vect_i;
  logic [NUM_RD_PORTS-1:0]             searchEn_i;
  logic [NUM_RD_PORTS-1:0][INDEX-1:0]  startIdx_i;
  logic [NUM_WR_PORTS-1:0]             setEn_i;
  logic [NUM_WR_PORTS-1:0][INDEX-1:0]  setAddr_i;
  logic [NUM_CLR_PORTS-1:0]            clrEn_i;
  logic [NUM_CLR_PORTS-1:0][INDEX-1:0] clrAddr_i;
  logic                                flush_i;
  logic [NUM_RD_PORTS-1:0]             hitValid_o;
  logic [NUM_RD_PORTS-1:0][INDEX-1:0]  hitIdx_o;
  logic [NUM_RD_PORTS-1:0]             multiHit_o;
  logic                                ready_o;

  modport master (
    output camReady_i, partitionGated_i,
    output readPortGated_i, vect_i,
    output searchEn_i, startIdx_i,
    output setEn_i, setAddr_i,
    output clrEn_i, clrAddr_i, flush_i,
    input  hitValid_o, hitIdx_o,
    input  multiHit_o, ready_o
  );

  modport slave (
    input  camReady_i, partitionGated_i,
    input  readPortGated_i, vect_i,
    input  searchEn_i, startIdx_i,
    input  setEn_i, setAddr_i,
    input  clrEn_i, clrAddr_i, flush_i,
    output hitValid_o, hitIdx_o,
    output multiHit_o, ready_o
  );

endinterface

// File: rtl/cam_match_select_circ_prio_enc.sv
// Circular priority encoder: first set bit at or after start, wrapping.
// Ports: vec/start in; valid (any bit set) and idx (winner) out.
module circ_prio_enc #(
  parameter int DEPTH = 32,
  parameter int INDEX = 5
) (
  input  logic [DEPTH-1:0] vec,
  input  logic [INDEX-1:0] start,
  output logic             valid,
  output logic [INDEX-1:0] idx
);

  logic [DEPTH-1:0] rot;
  logic [INDEX-1:0] pos;

  // Doubling the vector turns the rotate into a plain shift.
  assign rot = DEPTH'({vec, vec} >> start);

  always_comb begin
    pos = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rot[i]) pos = INDEX'(i);
    end
  end

  // Modulo-DEPTH add: carry out of INDEX bits is dropped.
  assign idx   = pos + start;
  assign valid = |vec;

endmodule

// File: rtl/cam_match_select.sv
// CAM match-select stage: masks raw matches, circular select, flush FSM.
// Ports: clk, reset (async high), bus (cam_match_select_if.slave).
module cam_match_select
  import cam_match_select_pkg::*;
(
  input logic              clk,
  input logic              reset,
  cam_match_select_if.slave bus
);

  camState_e                          state;
  logic [NUM_PARTS_LOG-1:0]           partCnt;
  logic                               readyQ;
  logic [DEPTH-1:0]                   validQ;
  logic [DEPTH-1:0]                   validD;
  logic [DEPTH-1:0]                   gatedMask;
  logic [NUM_RD_PORTS-1:0][DEPTH-1:0] qVec;
  logic [NUM_RD_PORTS-1:0]            encValid;
  logic [NUM_RD_PORTS-1:0][INDEX-1:0] encIdx;
  logic [NUM_RD_PORTS-1:0]            multi;
  logic [NUM_RD_PORTS-1:0]            hitValidQ;
  logic [NUM_RD_PORTS-1:0][INDEX-1:0] hitIdxQ;
  logic [NUM_RD_PORTS-1:0]            multiHitQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WAIT_RAM;
      partCnt <= '0;
      readyQ  <= 1'b0;
    end else begin
      unique case (state)
        WAIT_RAM: begin
          if (bus.camReady_i) begin
            state  <= RUN;
            readyQ <= 1'b1;
          end
        end
        RUN: begin
          if (bus.flush_i) begin
            state   <= FLUSH;
            partCnt <= '0;
            readyQ  <= 1'b0;
          end else if (!bus.camReady_i) begin
            state  <= WAIT_RAM;
            readyQ <= 1'b0;
          end
        end
        FLUSH: begin
          partCnt <= partCnt + 1'b1;
          if (partCnt == NUM_PARTS_LOG'(NUM_PARTS - 1)) begin
            state  <= RUN;
            readyQ <= 1'b1;
          end
        end
        default: begin
          state  <= WAIT_RAM;
          readyQ <= 1'b0;
        end
      endcase
    end
  end

  // Clears first so a same-cycle set wins; flush clear applied last.
  always_comb begin
    validD = validQ;
    for (int c = 0; c < NUM_CLR_PORTS; c++) begin
      if (bus.clrEn_i[c]) validD[bus.clrAddr_i[c]] = 1'b0;
    end
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (bus.setEn_i[w]) validD[bus.setAddr_i[w]] = 1'b1;
    end
    if (state == FLUSH) validD = validD & ~partMask(partCnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) validQ <= '0;
    else       validQ <= validD;
  end

  assign gatedMask = expandParts(bus.partitionGated_i);

  always_comb begin
    qVec = '0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      if (bus.searchEn_i[r] && !bus.readPortGated_i[r] &&
          state == RUN) begin
        qVec[r] = bus.vect_i[r] & validQ & ~gatedMask;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : gPort
    circ_prio_enc #(
      .DEPTH(DEPTH),
      .INDEX(INDEX)
    ) uEnc (
      .vec  (qVec[g]),
      .start(bus.startIdx_i[g]),
      .valid(encValid[g]),
      .idx  (encIdx[g])
    );
    // x & (x-1) drops the lowest set bit; nonzero means 2+ bits.
    assign multi[g] = |(qVec[g] & (qVec[g] - DEPTH'(1)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hitValidQ <= '0;
      hitIdxQ   <= '0;
      multiHitQ <= '0;
    end else begin
      hitValidQ <= encValid;
      multiHitQ <= multi;
      for (int r = 0; r < NUM_RD_PORTS; r++) begin
        hitIdxQ[r] <= encValid[r] ? encIdx[r] : '0;
      end
    end
  end

  assign bus.hitValid_o = hitValidQ;
  assign bus.hitIdx_o   = hitIdxQ;
  assign bus.multiHit_o = multiHitQ;
  assign bus.ready_o    = readyQ;

endmodule

// File: tb/tb_cam_match_select.sv
// Directed self-checking bench for cam_match_select.
// Drives on negedge, samples on the following negedge.
module tb_cam_match_select;
  import cam_match_select_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  cam_match_select_if camIf();

  cam_match_select dut (
    .clk  (clk),
    .reset(reset),
    .bus  (camIf.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    camIf.camReady_i       = 1'b0;
    camIf.partitionGated_i = '0;
    camIf.readPortGated_i  = '0;
    camIf.vect_i           = '0;
    camIf.searchEn_i       = '0;
    camIf.startIdx_i       = '0;
    camIf.setEn_i          = '0;
    camIf.setAddr_i        = '0;
    camIf.clrEn_i          = '0;
    camIf.clrAddr_i        = '0;
    camIf.flush_i          = 1'b0;
  endtask

  task automatic fillAll();
    camIf.setEn_i = 2'b11;
    for (int i = 0; i < DEPTH / 2; i++) begin
      camIf.setAddr_i[0] = INDEX'(2 * i);
      camIf.setAddr_i[1] = INDEX'(2 * i + 1);
      tick();
    end
    camIf.setEn_i = '0;
  endtask

  task automatic test_reset();
    idleInputs();
    reset = 1'b1;
    camIf.vect_i = '1;
    camIf.searchEn_i = 2'b11;
    #1;
    checks++; if (camIf.hitValid_o !== 2'b00) begin failures++;
      $display("FAIL rst_hitValid got=%b exp=00", camIf.hitValid_o); end
    checks++; if (camIf.hitIdx_o !== '0) begin failures++;
      $display("FAIL rst_hitIdx got=%h exp=0", camIf.hitIdx_o); end
    checks++; if (camIf.multiHit_o !== 2'b00) begin failures++;
      $display("FAIL rst_multiHit got=%b exp=00", camIf.multiHit_o); end
    checks++; if (camIf.ready_o !== 1'b0) begin failures++;
      $display("FAIL rst_ready got=%b exp=0", camIf.ready_o); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (camIf.ready_o !== 1'b0) begin failures++;
        $display("FAIL wait_ready c%0d got=%b exp=0", i, camIf.ready_o); end
      checks++; if (camIf.hitValid_o !== 2'b00) begin failures++;
        $display("FAIL wait_hit c%0d got=%b exp=00", i, camIf.hitValid_o); end
    end
    camIf.camReady_i = 1'b1;
    tick();
    checks++; if (camIf.ready_o !== 1'b1) begin failures++;
      $display("FAIL ready_rise got=%b exp=1", camIf.ready_o); end
  endtask

  task automatic test_select();
    camIf.setEn_i = 2'b11;
    camIf.setAddr_i[0] = 5'd3;
    camIf.setAddr_i[1] = 5'd9;
    tick();
    camIf.setEn_i = 2'b01;
    camIf.setAddr_i[0] = 5'd20;
    tick();
    camIf.setEn_i = '0;
    camIf.vect_i = '1;
    camIf.searchEn_i = 2'b11;
    camIf.startIdx_i[0] = 5'd10;
    camIf.startIdx_i[1] = 5'd0;
    tick();
    checks++; if (camIf.hitValid_o !== 2'b11) begin failures++;
      $display("FAIL sel_hitValid got=%b exp=11", camIf.hitValid_o); end
    checks++; if (camIf.hitIdx_o[0] !== 5'd20) begin failures++;
      $display("FAIL sel_idx0 got=%0d exp=20", camIf.hitIdx_o[0]); end
    checks++; if (camIf.hitIdx_o[1] !== 5'd3) begin failures++;
      $display("FAIL sel_idx1 got=%0d exp=3", camIf.hitIdx_o[1]); end
    checks++; if (camIf.multiHit_o !== 2'b11) begin failures++;
      $display("FAIL sel_multi got=%b exp=11", camIf.multiHit_o); end
  endtask

  task automatic test_wrap();
    camIf.clrEn_i[0] = 1'b1;
    camIf.clrAddr_i[0] = 5'd20;
    camIf.startIdx_i[0] = 5'd25;
    tick();
    camIf.clrEn_i = '0;
    tick();
    checks++; if (camIf.hitIdx_o[0] !== 5'd3) begin failures++;
      $display("FAIL wrap25 got=%0d exp=3", camIf.hitIdx_o[0]); end
    camIf.startIdx_i[0] = 5'd9;
    tick();
    checks++; if (camIf.hitIdx_o[0] !== 5'd9) begin failures++;
      $display("FAIL start9 got=%0d exp=9", camIf.hitIdx_o[0]); end
    checks++; if (camIf.multiHit_o[0] !== 1'b1) begin failures++;
      $display("FAIL start9_multi got=%b exp=1", camIf.multiHit_o[0]); end
    camIf.startIdx_i[0] = 5'd31;
    tick();
    checks++; if (camIf.hitIdx_o[0] !== 5'd3) begin failures++;
      $display("FAIL wrap31 got=%0d exp=3", camIf.hitIdx_o[0]); end
    camIf.startIdx_i[0] = 5'd10;
    tick();
    checks++; if (camIf.hitIdx_o[0] !== 5'd3) begin failures++;
      $display("FAIL clr20 got=%0d exp=3", camIf.hitIdx_o[0]); end
  endtask

  task automatic test_gating();
    camIf.partitionGated_i = 4'b0001;
    camIf.readPortGated_i = 2'b10;
    camIf.startIdx_i = '0;
    camIf.setEn_i[0] = 1'b1;
    camIf.setAddr_i[0] = 5'd1;
    tick();
    camIf.setEn_i = '0;
    checks++; if (camIf.hitValid_o !== 2'b01) begin failures++;
      $display("FAIL gate_hitValid got=%b exp=01", camIf.hitValid_o); end
    checks++; if (camIf.hitIdx_o[0] !== 5'd9) begin failures++;
      $display("FAIL gate_idx0 got=%0d exp=9", camIf.hitIdx_o[0]); end
    checks++; if (camIf.hitIdx_o[1] !== 5'd0) begin failures++;
      $display("FAIL gate_idx1 got=%0d exp=0", camIf.hitIdx_o[1]); end
    checks++; if (camIf.multiHit_o !== 2'b00) begin failures++;
      $display("FAIL gate_multi got=%b exp=00", camIf.multiHit_o); end
    camIf.partitionGated_i = '0;
    camIf.readPortGated_i = '0;
    tick();
    checks++; if (camIf.hitIdx_o[0] !== 5'd1) begin failures++;
      $display("FAIL gated_set got=%0d exp=1", camIf.hitIdx_o[0]); end
    camIf.clrEn_i[0] = 1'b1;
    camIf.clrAddr_i[0] = 5'd1;
    tick();
    camIf.clrEn_i = '0;
  endtask

  task automatic test_set_clr();
    camIf.vect_i[0] = 32'h0000_0020;
    camIf.vect_i[1] = '0;
    camIf.searchEn_i = 2'b01;
    camIf.startIdx_i = '0;
    camIf.setEn_i[0] = 1'b1;
    camIf.setAddr_i[0] = 5'd5;
    camIf.clrEn_i[1] = 1'b1;
    camIf.clrAddr_i[1] = 5'd5;
    tick();
    camIf.setEn_i = '0;
    camIf.clrEn_i = '0;
    checks++; if (camIf.hitValid_o[0] !== 1'b0) begin failures++;
      $display("FAIL setcyc_miss got=%b exp=0", camIf.hitValid_o[0]); end
    tick();
    checks++; if (camIf.hitValid_o[0] !== 1'b1) begin failures++;
      $display("FAIL setwin_hit got=%b exp=1", camIf.hitValid_o[0]); end
    checks++; if (camIf.hitIdx_o[0] !== 5'd5) begin failures++;
      $display("FAIL setwin_idx got=%0d exp=5", camIf.hitIdx_o[0]); end
    checks++; if (camIf.multiHit_o[0] !== 1'b0) begin failures++;
      $display("FAIL setwin_multi got=%b exp=0", camIf.multiHit_o[0]); end
  endtask

  task automatic test_flush();
    logic [DEPTH-1:0] expV [4];
    expV[0] = 32'hFFFF_FF00;
    expV[1] = 32'hFFFF_0000;
    expV[2] = 32'hFF00_0000;
    expV[3] = 32'h0000_0000;
    camIf.searchEn_i = '0;
    fillAll();
    camIf.vect_i = '1;
    camIf.searchEn_i = 2'b11;
    camIf.startIdx_i = '0;
    tick();
    checks++; if (camIf.multiHit_o !== 2'b11) begin failures++;
      $display("FAIL full_multi got=%b exp=11", camIf.multiHit_o); end
    camIf.flush_i = 1'b1;
    tick();
    checks++; if (camIf.ready_o !== 1'b0) begin failures++;
      $display("FAIL flush_ready0 got=%b exp=0", camIf.ready_o); end
    for (int p = 0; p < 4; p++) begin
      if (p == 2) camIf.flush_i = 1'b0;
      tick();
      checks++; if (dut.validQ !== expV[p]) begin failures++;
        $display("FAIL flush_p%0d got=%h exp=%h", p, dut.validQ, expV[p]); end
      checks++; if (camIf.ready_o !== (p == 3)) begin failures++;
        $display("FAIL flush_ready_p%0d got=%b exp=%b", p,
                 camIf.ready_o, (p == 3)); end
      checks++; if (camIf.hitValid_o !== 2'b00) begin failures++;
        $display("FAIL flush_hit_p%0d got=%b exp=00", p, camIf.hitValid_o); end
    end
    tick();
    checks++; if (camIf.hitValid_o !== 2'b00) begin failures++;
      $display("FAIL post_flush_hit got=%b exp=00", camIf.hitValid_o); end
  endtask

  task automatic test_reset_mid_flush();
    camIf.searchEn_i = '0;
    fillAll();
    camIf.flush_i = 1'b1;
    tick();
    camIf.flush_i = 1'b0;
    tick();
    #1 reset = 1'b1;
    #1;
    checks++; if (dut.state !== WAIT_RAM) begin failures++;
      $display("FAIL mid_flush_state got=%0d exp=%0d", dut.state, WAIT_RAM); end
    checks++; if (dut.validQ !== '0) begin failures++;
      $display("FAIL mid_flush_valid got=%h exp=0", dut.validQ); end
    checks++; if (camIf.ready_o !== 1'b0) begin failures++;
      $display("FAIL mid_flush_ready got=%b exp=0", camIf.ready_o); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_ready_drop_and_async();
    camIf.camReady_i = 1'b1;
    camIf.setEn_i[0] = 1'b1;
    camIf.setAddr_i[0] = 5'd7;
    tick();
    camIf.setEn_i = '0;
    camIf.vect_i = '1;
    camIf.searchEn_i = 2'b01;
    camIf.startIdx_i = '0;
    camIf.camReady_i = 1'b0;
    tick();
    checks++; if (camIf.ready_o !== 1'b0) begin failures++;
      $display("FAIL drop_ready got=%b exp=0", camIf.ready_o); end
    tick();
    checks++; if (camIf.hitValid_o !== 2'b00) begin failures++;
      $display("FAIL drop_hit got=%b exp=00", camIf.hitValid_o); end
    camIf.camReady_i = 1'b1;
    tick();
    tick();
    checks++; if (camIf.hitIdx_o[0] !== 5'd7) begin failures++;
      $display("FAIL held_valid got=%0d exp=7", camIf.hitIdx_o[0]); end
    checks++; if (camIf.hitValid_o !== 2'b01) begin failures++;
      $display("FAIL held_hit got=%b exp=01", camIf.hitValid_o); end
    #1 reset = 1'b1;
    #1;
    checks++; if (camIf.hitValid_o !== 2'b00) begin failures++;
      $display("FAIL async_hit got=%b exp=00", camIf.hitValid_o); end
    checks++; if (camIf.hitIdx_o !== '0) begin failures++;
      $display("FAIL async_idx got=%h exp=0", camIf.hitIdx_o); end
    checks++; if (camIf.ready_o !== 1'b0) begin failures++;
      $display("FAIL async_ready got=%b exp=0", camIf.ready_o); end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_select();
    test_wrap();
    test_gating();
    test_set_clr();
    test_flush();
    test_reset_mid_flush();
    test_ready_drop_and_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
